// File: rtl/pcfx_media_loader.sv
// pcfx_media_loader: media / backup-storage front end of the PC-FX core.
//   - ROM path: ioctl index-0 download words are forwarded one at a time to a
//     single-word SDRAM write port (mem_req/mem_ack), back-pressuring the host
//     with ioctl_wait while a write is outstanding.
//   - Backup path: loads/saves up to BK_SECTORS 512-byte sectors between the
//     internal backup word RAM (bram_*) and a mounted SD image (sd_*).
// Ports:
//   clk_sys, reset_n                 clock, synchronous active-low reset
//   ioctl_* / mem_*                  BIOS download in, SDRAM write out
//   img_*                            image mount notification
//   sd_*                             HPS sector block handshake
//   bk_*                             backup control / status
//   bram_*                           backup RAM port (1-cycle synchronous read)
module pcfx_media_loader #(
  parameter logic [24:0] ROM_BASE_A = 25'h0000000,
  parameter int unsigned BK_SECTORS = 64
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_req,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  output logic [15:0] sd_buff_din,
  input  logic        sd_buff_wr,
  output logic        bk_ena,
  input  logic        bk_load,
  input  logic        bk_save,
  output logic        bk_loading,
  output logic [13:0] bram_addr,
  output logic [15:0] bram_wdata,
  output logic        bram_we,
  input  logic [15:0] bram_rdata
);

  localparam int unsigned LBA_W = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT
  } state_t;

  // ROM path registers
  logic        r_mem_req;
  logic        r_ioctl_wait;
  logic        r_wait_clr;
  logic [24:0] r_mem_addr;
  logic [15:0] r_mem_wdata;

  // Mount registers
  logic [LBA_W-1:0] r_nsect;
  logic             r_ro;
  logic             r_bk_ena;

  // Backup FSM registers
  state_t           r_state;
  logic [LBA_W-1:0] r_lba;
  logic             r_sd_rd;
  logic             r_sd_wr;
  logic             r_bk_loading;
  logic             r_load_d;
  logic             r_save_d;
  logic             r_ack_d;

  logic [54:0]      w_size_sect;
  logic [LBA_W-1:0] w_nsect;
  logic             w_load_rise;
  logic             w_save_rise;
  logic             w_ack_fall;
  logic [LBA_W-1:0] w_lba_next;
  logic             w_unused;

  // Image size in whole sectors, clamped to the backup RAM capacity
  assign w_size_sect = img_size[63:9];
  assign w_nsect     = (w_size_sect >= 55'(BK_SECTORS)) ? LBA_W'(BK_SECTORS)
                                                        : w_size_sect[LBA_W-1:0];
  assign w_unused    = ^img_size[8:0];

  assign w_load_rise = bk_load & ~r_load_d;
  assign w_save_rise = bk_save & ~r_save_d;
  assign w_ack_fall  = ~sd_ack & r_ack_d;
  assign w_lba_next  = r_lba + LBA_W'(1);

  // ROM download: one outstanding SDRAM write; wait drops one cycle after ack
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_mem_req    <= 1'b0;
      r_ioctl_wait <= 1'b0;
      r_wait_clr   <= 1'b0;
      r_mem_addr   <= 25'd0;
      r_mem_wdata  <= 16'd0;
    end else begin
      r_wait_clr <= 1'b0;
      if (r_wait_clr) begin
        r_ioctl_wait <= 1'b0;
      end
      if (r_mem_req && mem_ack) begin
        r_mem_req  <= 1'b0;
        r_wait_clr <= 1'b1;
      end else if (!r_ioctl_wait && ioctl_wr && ioctl_download &&
                   (ioctl_index == 8'd0)) begin
        r_mem_addr   <= ROM_BASE_A + ioctl_addr;
        r_mem_wdata  <= ioctl_dout;
        r_mem_req    <= 1'b1;
        r_ioctl_wait <= 1'b1;
      end
    end
  end

  // Mount: capture usable sector count and write protection
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_nsect  <= '0;
      r_ro     <= 1'b0;
      r_bk_ena <= 1'b0;
    end else if (img_mounted) begin
      r_nsect  <= w_nsect;
      r_ro     <= img_readonly;
      r_bk_ena <= (w_nsect != '0);
    end
  end

  // Backup sector sequencer
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_lba        <= '0;
      r_sd_rd      <= 1'b0;
      r_sd_wr      <= 1'b0;
      r_bk_loading <= 1'b0;
      r_load_d     <= 1'b0;
      r_save_d     <= 1'b0;
      r_ack_d      <= 1'b0;
    end else begin
      r_load_d <= bk_load;
      r_save_d <= bk_save;
      r_ack_d  <= sd_ack;
      case (r_state)
        S_IDLE: begin
          // Load takes priority when both edges land together
          if (w_load_rise && r_bk_ena) begin
            r_state      <= S_RD_REQ;
            r_lba        <= '0;
            r_sd_rd      <= 1'b1;
            r_bk_loading <= 1'b1;
          end else if (w_save_rise && r_bk_ena && !r_ro) begin
            r_state <= S_WR_REQ;
            r_lba   <= '0;
            r_sd_wr <= 1'b1;
          end
        end
        S_RD_REQ: begin
          if (sd_ack) begin
            r_sd_rd <= 1'b0;
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (w_ack_fall) begin
            r_lba <= w_lba_next;
            if (w_lba_next == r_nsect) begin
              r_state      <= S_IDLE;
              r_bk_loading <= 1'b0;
            end else begin
              r_state <= S_RD_REQ;
              r_sd_rd <= 1'b1;
            end
          end
        end
        S_WR_REQ: begin
          if (sd_ack) begin
            r_sd_wr <= 1'b0;
            r_state <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (w_ack_fall) begin
            r_lba <= w_lba_next;
            if (w_lba_next == r_nsect) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_WR_REQ;
              r_sd_wr <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ioctl_wait = r_ioctl_wait;
  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

  assign sd_lba     = 32'(r_lba);
  assign sd_rd      = r_sd_rd;
  assign sd_wr      = r_sd_wr;
  assign bk_ena     = r_bk_ena;
  assign bk_loading = r_bk_loading;

  // Buffer port is passed straight through so each host word lands the same cycle
  assign bram_addr   = {r_lba[5:0], sd_buff_addr};
  assign bram_wdata  = sd_buff_dout;
  assign bram_we     = (r_state == S_RD_WAIT) & sd_buff_wr;
  assign sd_buff_din = bram_rdata;

endmodule

// File: tb/tb_pcfx_media_loader.sv
// Testbench for pcfx_media_loader: host-side models for ioctl, SDRAM, SD block
// handshake and backup RAM, with randomized data checked against a reference
// image/backup model.
module tb_pcfx_media_loader;

  localparam logic [24:0] TB_ROM_BASE = 25'h0100000;

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic        mem_req;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic        img_mounted;
  logic        img_readonly;
  logic [63:0] img_size;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic [15:0] sd_buff_din;
  logic        sd_buff_wr;
  logic        bk_ena;
  logic        bk_load;
  logic        bk_save;
  logic        bk_loading;
  logic [13:0] bram_addr;
  logic [15:0] bram_wdata;
  logic        bram_we;
  logic [15:0] bram_rdata;

  int checks = 0;
  int errors = 0;

  logic [15:0] img    [0:16383];
  logic [15:0] ref_bk [0:16383];
  logic [15:0] bram_mem [0:16383];

  pcfx_media_loader #(.ROM_BASE_A(TB_ROM_BASE), .BK_SECTORS(64)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
    .sd_buff_wr(sd_buff_wr), .bk_ena(bk_ena), .bk_load(bk_load), .bk_save(bk_save),
    .bk_loading(bk_loading), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_we(bram_we), .bram_rdata(bram_rdata)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Backup RAM: synchronous write, registered read
  always @(posedge clk_sys) begin
    if (bram_we) bram_mem[bram_addr] <= bram_wdata;
    bram_rdata <= bram_mem[bram_addr];
  end

  task automatic randomize_img();
    for (int i = 0; i < 16384; i++) img[i] = 16'($urandom);
  endtask

  task automatic mount(input logic [63:0] size, input logic ro);
    logic exp_ena;
    exp_ena = ((size >> 9) != 64'd0);
    @(negedge clk_sys);
    img_size = size; img_readonly = ro; img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
    checks++;
    if (bk_ena !== exp_ena) begin
      errors++;
      $display("FAIL mount_bk_ena size=%0d got=%b exp=%b", size, bk_ena, exp_ena);
    end
  endtask

  task automatic pulse_load();
    @(negedge clk_sys); bk_load = 1'b1;
    @(negedge clk_sys); bk_load = 1'b0;
  endtask

  task automatic pulse_save();
    @(negedge clk_sys); bk_save = 1'b1;
    @(negedge clk_sys); bk_save = 1'b0;
  endtask

  // Host side of one sector transfer; checks lba, request release and every word
  task automatic serve_sector(input bit is_wr, input int exp_lba, output bit ok);
    int n;
    int base;
    logic [15:0] exp_w;
    ok = 1'b0;
    n = 0;
    base = exp_lba * 256;
    while (((is_wr ? sd_wr : sd_rd) !== 1'b1) && n < 40) begin
      @(negedge clk_sys); n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL sector_req_timeout lba=%0d wr=%0d got=0 exp=1", exp_lba, is_wr);
      return;
    end
    checks++;
    if (sd_lba !== 32'(exp_lba)) begin
      errors++;
      $display("FAIL sector_lba got=%0d exp=%0d", sd_lba, exp_lba);
    end
    sd_ack = 1'b1;
    @(negedge clk_sys);
    checks++;
    if ((is_wr ? sd_wr : sd_rd) !== 1'b0) begin
      errors++;
      $display("FAIL req_release lba=%0d got=1 exp=0", exp_lba);
    end
    if (!is_wr) begin
      for (int w = 0; w < 256; w++) begin
        sd_buff_addr = 8'(w);
        sd_buff_dout = img[base + w];
        sd_buff_wr = 1'b1;
        #1;
        checks++;
        if ({bram_we, bram_addr, bram_wdata} !== {1'b1, 14'(base + w), img[base + w]}) begin
          errors++;
          $display("FAIL load_word lba=%0d w=%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h",
                   exp_lba, w, bram_we, bram_addr, bram_wdata, 14'(base + w), img[base + w]);
        end
        @(negedge clk_sys);
      end
      sd_buff_wr = 1'b0;
    end else begin
      sd_buff_addr = 8'd0;
      @(negedge clk_sys);
      for (int w = 0; w < 256; w++) begin
        exp_w = ref_bk[base + w];
        checks++;
        if (sd_buff_din !== exp_w || bram_we !== 1'b0) begin
          errors++;
          $display("FAIL save_word lba=%0d w=%0d got din=%h we=%b exp din=%h we=0",
                   exp_lba, w, sd_buff_din, bram_we, exp_w);
        end
        sd_buff_addr = 8'(w + 1);
        @(negedge clk_sys);
      end
    end
    sd_ack = 1'b0;
    @(negedge clk_sys);
    ok = 1'b1;
  endtask

  // Run a whole load of nsect sectors and update the reference backup image
  task automatic run_load(input int nsect);
    bit ok;
    pulse_load();
    checks++;
    if (bk_loading !== 1'b1) begin
      errors++;
      $display("FAIL load_start bk_loading got=%b exp=1", bk_loading);
    end
    for (int s = 0; s < nsect; s++) begin
      serve_sector(1'b0, s, ok);
      if (!ok) return;
      for (int w = 0; w < 256; w++) ref_bk[s * 256 + w] = img[s * 256 + w];
      checks++;
      if (bk_loading !== (s != nsect - 1)) begin
        errors++;
        $display("FAIL load_busy s=%0d got=%b exp=%b", s, bk_loading, (s != nsect - 1));
      end
    end
    begin
      bit extra;
      extra = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk_sys);
        if (sd_rd !== 1'b0) extra = 1'b1;
      end
      checks++;
      if (extra) begin
        errors++;
        $display("FAIL load_extra_sector got sd_rd=1 exp=0 nsect=%0d", nsect);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({ioctl_wait, mem_req, sd_rd, sd_wr, bk_ena, bk_loading, bram_we, sd_lba} !== 39'd0) begin
      errors++;
      $display("FAIL reset_state got wait=%b req=%b rd=%b wr=%b ena=%b ld=%b we=%b lba=%0d exp all 0",
               ioctl_wait, mem_req, sd_rd, sd_wr, bk_ena, bk_loading, bram_we, sd_lba);
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic rom_write(input logic [24:0] a, input logic [15:0] d, input int ack_dly);
    logic [24:0] exp_a;
    exp_a = TB_ROM_BASE + a;
    @(negedge clk_sys);
    ioctl_download = 1'b1; ioctl_index = 8'd0; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    checks++;
    if ({mem_req, ioctl_wait, mem_addr, mem_wdata} !== {1'b1, 1'b1, exp_a, d}) begin
      errors++;
      $display("FAIL rom_req got req=%b wait=%b a=%h d=%h exp req=1 wait=1 a=%h d=%h",
               mem_req, ioctl_wait, mem_addr, mem_wdata, exp_a, d);
    end
    for (int c = 1; c < ack_dly; c++) begin
      @(negedge clk_sys);
      checks++;
      if ({mem_req, ioctl_wait} !== 2'b11) begin
        errors++;
        $display("FAIL rom_hold c=%0d got req=%b wait=%b exp 1 1", c, mem_req, ioctl_wait);
      end
    end
    mem_ack = 1'b1;
    @(negedge clk_sys);
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, ioctl_wait} !== 2'b01) begin
      errors++;
      $display("FAIL rom_ack_edge got req=%b wait=%b exp req=0 wait=1", mem_req, ioctl_wait);
    end
    @(negedge clk_sys);
    checks++;
    if ({mem_req, ioctl_wait} !== 2'b00) begin
      errors++;
      $display("FAIL rom_wait_release got req=%b wait=%b exp 0 0", mem_req, ioctl_wait);
    end
  endtask

  task automatic test_rom();
    rom_write(25'h000004, 16'hBEEF, 3);
    for (int k = 0; k < 8; k++)
      rom_write(25'($urandom) & ~25'd1, 16'($urandom), int'($urandom_range(1, 5)));
    ioctl_download = 1'b0;
  endtask

  task automatic test_rom_ignore();
    bit seen;
    seen = 1'b0;
    @(negedge clk_sys);
    ioctl_download = 1'b1; ioctl_index = 8'd1; ioctl_addr = 25'h10; ioctl_dout = 16'h1234; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (mem_req !== 1'b0 || ioctl_wait !== 1'b0) seen = 1'b1;
      @(negedge clk_sys);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rom_index1_ignored got req/wait asserted exp none");
    end
    ioctl_download = 1'b0; ioctl_index = 8'd0;
  endtask

  task automatic test_mount_small();
    bit seen;
    seen = 1'b0;
    mount(64'd100, 1'b0);
    pulse_load();
    for (int c = 0; c < 10; c++) begin
      if (sd_rd !== 1'b0 || bk_loading !== 1'b0) seen = 1'b1;
      @(negedge clk_sys);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL empty_image_load got sd_rd/bk_loading=1 exp 0");
    end
  endtask

  task automatic test_load_full();
    randomize_img();
    mount(64'd32768, 1'b0);
    run_load(64);
  endtask

  task automatic test_load_small();
    randomize_img();
    mount(64'd1024, 1'b0);
    run_load(2);
  endtask

  task automatic test_save();
    bit seen;
    bit ok;
    seen = 1'b0;
    mount(64'd32768, 1'b1);
    pulse_save();
    for (int c = 0; c < 20; c++) begin
      if (sd_wr !== 1'b0) seen = 1'b1;
      @(negedge clk_sys);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL save_readonly got sd_wr=1 exp 0");
    end
    mount(64'd32768, 1'b0);
    pulse_save();
    checks++;
    if (bk_loading !== 1'b0) begin
      errors++;
      $display("FAIL save_not_loading got=%b exp=0", bk_loading);
    end
    for (int s = 0; s < 64; s++) begin
      serve_sector(1'b1, s, ok);
      if (!ok) return;
    end
    repeat (5) @(negedge clk_sys);
    checks++;
    if (sd_wr !== 1'b0) begin
      errors++;
      $display("FAIL save_extra_sector got sd_wr=1 exp 0");
    end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    int n;
    randomize_img();
    mount(64'd32768, 1'b0);
    pulse_load();
    for (int s = 0; s < 10; s++) begin
      serve_sector(1'b0, s, ok);
      if (!ok) return;
    end
    n = 0;
    while (sd_rd !== 1'b1 && n < 40) begin @(negedge clk_sys); n++; end
    sd_ack = 1'b1;
    @(negedge clk_sys);
    for (int w = 0; w < 20; w++) begin
      sd_buff_addr = 8'(w); sd_buff_dout = img[2560 + w]; sd_buff_wr = 1'b1;
      @(negedge clk_sys);
    end
    sd_buff_wr = 1'b0;
    reset_n = 1'b0;
    sd_ack = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({sd_rd, bk_loading} !== 2'b00) begin
      errors++;
      $display("FAIL reset_abort got rd=%b loading=%b exp 0 0", sd_rd, bk_loading);
    end
    reset_n = 1'b1;
    @(negedge clk_sys);
    randomize_img();
    mount(64'd2048, 1'b0);
    run_load(4);
  endtask

  initial begin
    reset_n = 1'b0;
    ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = 25'd0; ioctl_dout = 16'd0; mem_ack = 1'b0;
    img_mounted = 1'b0; img_readonly = 1'b0; img_size = 64'd0;
    sd_ack = 1'b0; sd_buff_addr = 8'd0; sd_buff_dout = 16'd0; sd_buff_wr = 1'b0;
    bk_load = 1'b0; bk_save = 1'b0;
    for (int i = 0; i < 16384; i++) ref_bk[i] = 16'd0;

    test_reset();
    test_rom();
    test_rom_ignore();
    test_mount_small();
    test_load_full();
    test_load_small();
    test_save();
    test_reset_mid_load();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
